// File: rtl/spider_resource_manager.sv
// ============================================================================
// Module   : spider_resource_manager
// Purpose  : Holds web, energy and tracer reserves. Each gadget request is
//            checked and then granted (all three deducted) or denied (nothing
//            deducted). Refills add to the reserves with saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spider_resource_manager #(
  parameter int WEB_MAX    = 200,
  parameter int ENERGY_MAX = 1000,
  parameter int TRACER_MAX = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] webNeeded,
  input  logic [7:0] energyNeeded,
  input  logic [5:0] tracersNeeded,
  input  logic       refill_valid,
  output logic       refill_ready,
  input  logic [7:0] refill_web,
  input  logic [9:0] refill_energy,
  input  logic [5:0] refill_tracers,
  output logic       grant,
  output logic       deny,
  output logic [7:0] web_level,
  output logic [9:0] energy_level,
  output logic [5:0] tracer_level,
  output logic       low_energy,
  output logic [7:0] deny_count
);

  localparam logic [8:0]  c_WEB_MAX    = WEB_MAX[8:0];
  localparam logic [10:0] c_ENERGY_MAX = ENERGY_MAX[10:0];
  localparam logic [6:0]  c_TRACER_MAX = TRACER_MAX[6:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_web_req;
  logic [7:0]  r_energy_req;
  logic [5:0]  r_tracer_req;
  logic        r_sufficient;
  logic        r_grant;
  logic        r_deny;
  logic [7:0]  r_web;
  logic [9:0]  r_energy;
  logic [5:0]  r_tracer;
  logic [7:0]  r_deny_count;
  logic        w_req_ready;
  logic        w_refill_ready;
  logic        w_req_accept;
  logic        w_refill_accept;
  logic        w_sufficient;
  logic [8:0]  w_web_sum;
  logic [10:0] w_energy_sum;
  logic [6:0]  w_tracer_sum;

  // State register; reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and handshake readiness; a pending request blocks refills.
  always_comb begin
    w_state_next   = r_state;
    w_req_ready    = 1'b0;
    w_refill_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready    = 1'b1;
        w_refill_ready = ~req_valid;
        if (req_valid) w_state_next = CHECK;
      end
      CHECK:   w_state_next = RESULT;
      RESULT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_req_accept    = req_valid & w_req_ready;
  assign w_refill_accept = refill_valid & w_refill_ready;

  // All-or-nothing sufficiency test against the captured request.
  assign w_sufficient = (r_web    >= {4'd0, r_web_req})    &&
                        (r_energy >= {2'd0, r_energy_req}) &&
                        (r_tracer >= r_tracer_req);

  // One extra bit on each sum so the saturation compare cannot be fooled by wrap.
  assign w_web_sum    = {1'b0, r_web}    + {1'b0, refill_web};
  assign w_energy_sum = {1'b0, r_energy} + {1'b0, refill_energy};
  assign w_tracer_sum = {1'b0, r_tracer} + {1'b0, refill_tracers};

  // Request capture, decision, deduction, refill and denial counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_web_req    <= '0;
      r_energy_req <= '0;
      r_tracer_req <= '0;
      r_sufficient <= 1'b0;
      r_grant      <= 1'b0;
      r_deny       <= 1'b0;
      r_web        <= c_WEB_MAX[7:0];
      r_energy     <= c_ENERGY_MAX[9:0];
      r_tracer     <= c_TRACER_MAX[5:0];
      r_deny_count <= '0;
    end else begin
      r_grant <= 1'b0;
      r_deny  <= 1'b0;
      if (w_req_accept) begin
        r_web_req    <= webNeeded;
        r_energy_req <= energyNeeded;
        r_tracer_req <= tracersNeeded;
      end
      if (r_state == CHECK) begin
        r_sufficient <= w_sufficient;
        r_grant      <= w_sufficient;
        r_deny       <= ~w_sufficient;
      end
      if (r_state == RESULT) begin
        if (r_sufficient) begin
          r_web    <= r_web    - {4'd0, r_web_req};
          r_energy <= r_energy - {2'd0, r_energy_req};
          r_tracer <= r_tracer - r_tracer_req;
        end else if (r_deny_count != 8'hFF) begin
          r_deny_count <= r_deny_count + 8'd1;
        end
      end
      if (w_refill_accept) begin
        r_web    <= (w_web_sum    > c_WEB_MAX)    ? c_WEB_MAX[7:0]    : w_web_sum[7:0];
        r_energy <= (w_energy_sum > c_ENERGY_MAX) ? c_ENERGY_MAX[9:0] : w_energy_sum[9:0];
        r_tracer <= (w_tracer_sum > c_TRACER_MAX) ? c_TRACER_MAX[5:0] : w_tracer_sum[5:0];
      end
    end
  end

  assign req_ready    = w_req_ready;
  assign refill_ready = w_refill_ready;
  assign grant        = r_grant;
  assign deny         = r_deny;
  assign web_level    = r_web;
  assign energy_level = r_energy;
  assign tracer_level = r_tracer;
  assign deny_count   = r_deny_count;
  assign low_energy   = (r_energy < 10'd16);

endmodule

`default_nettype wire
